// File: rtl/bus_arb2to1.sv
// Two-master, one-slave round-robin arbiter for the 32-bit valid/ready memory bus.
// Each grant covers one transfer; a per-transfer wait limit force-completes stalled transfers.
module bus_arb2to1 #(
    parameter logic [15:0] TIMEOUT  = 16'd1024,
    parameter logic [31:0] TO_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m2_valid,
    output logic        m2_ready,
    input  logic [31:0] m2_addr,
    output logic [31:0] m2_rdata,
    input  logic [31:0] m2_wdata,
    input  logic [3:0]  m2_wstrb,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    input  logic [31:0] s_rdata,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic [1:0]  grant,
    output logic        timeout
);

    localparam int          N          = 2;
    localparam logic [15:0] WAIT_LAST  = TIMEOUT - 16'd1;
    localparam logic        TIMEOUT_EN = (TIMEOUT != 16'd0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_reg;
    logic [1:0]  grant_reg;
    logic        last_reg;       // 0 = m1 granted most recently, 1 = m2
    logic [15:0] wait_cnt_reg;

    // Master-side signals gathered into arrays so the per-master logic is uniform.
    logic        req_valid [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];

    logic [31:0] addr_term  [N];
    logic [31:0] wdata_term [N];
    logic [3:0]  wstrb_term [N];

    assign req_valid[0] = m1_valid;
    assign req_addr[0]  = m1_addr;
    assign req_wdata[0] = m1_wdata;
    assign req_wstrb[0] = m1_wstrb;
    assign req_valid[1] = m2_valid;
    assign req_addr[1]  = m2_addr;
    assign req_wdata[1] = m2_wdata;
    assign req_wstrb[1] = m2_wstrb;

    assign m1_ready = rsp_ready[0];
    assign m1_rdata = rsp_rdata[0];
    assign m2_ready = rsp_ready[1];
    assign m2_rdata = rsp_rdata[1];

    logic busy;
    logic wait_expired;
    logic xfer_done;
    logic win_valid;
    logic win_sel;

    assign busy         = (state_reg == ST_BUSY);
    assign wait_expired = TIMEOUT_EN && busy && !s_ready && (wait_cnt_reg == WAIT_LAST);
    assign xfer_done    = busy && (s_ready || wait_expired);

    // A tie goes to whichever master did not own the previous transfer.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = 1'b0;
        case ({req_valid[1], req_valid[0]})
            2'b01: begin
                win_valid = 1'b1;
                win_sel   = 1'b0;
            end
            2'b10: begin
                win_valid = 1'b1;
                win_sel   = 1'b1;
            end
            2'b11: begin
                win_valid = 1'b1;
                win_sel   = ~last_reg;
            end
            default: begin
                win_valid = 1'b0;
                win_sel   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 2'b00;
            last_reg     <= 1'b1;
            wait_cnt_reg <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_reg    <= ST_BUSY;
                        grant_reg    <= win_sel ? 2'b10 : 2'b01;
                        last_reg     <= win_sel;
                        wait_cnt_reg <= 16'd0;
                    end
                end
                ST_BUSY: begin
                    if (xfer_done) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= 2'b00;
                    end else if (wait_cnt_reg != 16'hFFFF) begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

    // grant_reg is zero outside BUSY, so masking by it alone also zeroes the idle slave bus.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_master
            assign addr_term[gi]  = req_addr[gi]  & {32{grant_reg[gi]}};
            assign wdata_term[gi] = req_wdata[gi] & {32{grant_reg[gi]}};
            assign wstrb_term[gi] = req_wstrb[gi] & {4{grant_reg[gi]}};
            assign rsp_ready[gi]  = grant_reg[gi] & xfer_done;
            assign rsp_rdata[gi]  = rsp_ready[gi] ? (s_ready ? s_rdata : TO_RDATA) : 32'd0;
        end
    endgenerate

    always_comb begin
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        for (int i = 0; i < N; i++) begin
            s_addr  = s_addr  | addr_term[i];
            s_wdata = s_wdata | wdata_term[i];
            s_wstrb = s_wstrb | wstrb_term[i];
        end
    end

    assign s_valid = busy;
    assign grant   = grant_reg;
    assign timeout = wait_expired;

endmodule

// File: tb/tb_bus_arb2to1.sv
// Self-checking bench for bus_arb2to1: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_bus_arb2to1;

    localparam int          TO_CYC   = 4;
    localparam logic [31:0] TO_VALUE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m1_valid = 1'b0, m2_valid = 1'b0;
    logic        m1_ready, m2_ready;
    logic [31:0] m1_addr = '0, m2_addr = '0, m1_wdata = '0, m2_wdata = '0;
    logic [31:0] m1_rdata, m2_rdata;
    logic [3:0]  m1_wstrb = '0, m2_wstrb = '0;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    bus_arb2to1 #(
        .TIMEOUT (16'd4),
        .TO_RDATA(TO_VALUE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m1_valid(m1_valid),
        .m1_ready(m1_ready),
        .m1_addr (m1_addr),
        .m1_rdata(m1_rdata),
        .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb),
        .m2_valid(m2_valid),
        .m2_ready(m2_ready),
        .m2_addr (m2_addr),
        .m2_rdata(m2_rdata),
        .m2_wdata(m2_wdata),
        .m2_wstrb(m2_wstrb),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_rdata (s_rdata),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
    task automatic apply_reset();
        rst = 1'b1;
        m1_valid = 1'b0; m2_valid = 1'b0; s_ready = 1'b0;
        m1_addr = '0; m2_addr = '0; m1_wdata = '0; m2_wdata = '0;
        m1_wstrb = '0; m2_wstrb = '0; s_rdata = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m1_valid = 1'b1; m1_addr = 32'h1234_5678; s_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if ({m1_ready, m2_ready, timeout} !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b expected 000", {m1_ready, m2_ready, timeout}); end
        checks++; if (s_addr !== 32'd0) begin failures++; $display("FAIL reset_s_addr: got %h expected 0", s_addr); end
        m1_valid = 1'b0; s_ready = 1'b0; m1_addr = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_idle_grant: got %b expected 00", grant); end
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_single();
        int busy_seen = 0, sv_k = -1, rdy_k = -1, rdy_n = 0, m2_n = 0;
        logic [31:0] got = '0;
        logic [31:0] addr_seen = '0;
        m1_addr = 32'h0000_0100; m1_wdata = $urandom; m1_wstrb = 4'h0; m2_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            m1_valid = (rdy_n == 0);
            s_ready  = s_valid && (busy_seen == 2);
            s_rdata  = s_ready ? 32'hCAFE_F00D : $urandom;
            if (s_valid) busy_seen++;
            @(negedge clk);
            if (s_valid && sv_k < 0) begin sv_k = k; addr_seen = s_addr; end
            if (m2_ready) m2_n++;
            if (m1_ready) begin rdy_n++; rdy_k = k; got = m1_rdata; end
            @(posedge clk); #1;
        end
        m1_valid = 1'b0; s_ready = 1'b0;
        checks++; if (sv_k !== 1) begin failures++; $display("FAIL single_svalid_latency: got %0d expected 1", sv_k); end
        checks++; if (addr_seen !== 32'h0000_0100) begin failures++; $display("FAIL single_s_addr: got %h expected 00000100", addr_seen); end
        checks++; if (rdy_n !== 1) begin failures++; $display("FAIL single_ready_count: got %0d expected 1", rdy_n); end
        checks++; if (rdy_k !== 3) begin failures++; $display("FAIL single_ready_cycle: got %0d expected 3", rdy_k); end
        checks++; if (got !== 32'hCAFE_F00D) begin failures++; $display("FAIL single_rdata: got %h expected cafef00d", got); end
        checks++; if (m2_n !== 0) begin failures++; $display("FAIL single_m2_ready: got %0d pulses expected 0", m2_n); end
        $display("txn single m1 read addr=00000100 rdata=%h", got);
    endtask

    task automatic test_tie();
        logic [1:0] glog [8];
        int m1_k = -1, m2_k = -1, sv2_k = -1;
        logic [31:0] rd_exp = '0, rd_got = '0;
        apply_reset();
        m1_addr = 32'h0000_1000; m2_addr = 32'h0000_2000;
        for (int k = 0; k < 8; k++) begin
            m1_valid = (m1_k < 0);
            m2_valid = (m2_k < 0);
            s_ready  = s_valid;
            s_rdata  = $urandom;
            @(negedge clk);
            glog[k] = grant;
            if (s_valid && m1_k >= 0 && sv2_k < 0) sv2_k = k;
            if (m1_ready && m1_k < 0) m1_k = k;
            if (m2_ready && m2_k < 0) begin m2_k = k; rd_got = m2_rdata; rd_exp = s_rdata; end
            @(posedge clk); #1;
        end
        m1_valid = 1'b0; m2_valid = 1'b0; s_ready = 1'b0;
        checks++; if (glog[1] !== 2'b01) begin failures++; $display("FAIL tie_grant1: got %b expected 01", glog[1]); end
        checks++; if (glog[2] !== 2'b00) begin failures++; $display("FAIL tie_grant2: got %b expected 00", glog[2]); end
        checks++; if (glog[3] !== 2'b10) begin failures++; $display("FAIL tie_grant3: got %b expected 10", glog[3]); end
        checks++; if (m1_k !== 1) begin failures++; $display("FAIL tie_m1_ready_cycle: got %0d expected 1", m1_k); end
        checks++; if (m2_k !== 3) begin failures++; $display("FAIL tie_m2_ready_cycle: got %0d expected 3", m2_k); end
        checks++; if (sv2_k !== m1_k + 2) begin failures++; $display("FAIL tie_second_svalid: got %0d expected %0d", sv2_k, m1_k + 2); end
        checks++; if (rd_got !== rd_exp) begin failures++; $display("FAIL tie_m2_rdata: got %h expected %h", rd_got, rd_exp); end
        $display("txn tie m1@%0d m2@%0d", m1_k, m2_k);
    endtask

    task automatic test_contention();
        int done = 0, n1 = 0, n2 = 0;
        int exp_owner;
        logic [1:0] got_rdy, exp_rdy;
        apply_reset();
        for (int k = 0; k < 80 && done < 6; k++) begin
            m1_valid = 1'b1; m1_addr = 32'h1000_0000 + n1 * 4; m1_wdata = 32'hA000_0000 + n1; m1_wstrb = 4'hF;
            m2_valid = 1'b1; m2_addr = 32'h2000_0000 + n2 * 4; m2_wdata = 32'hB000_0000 + n2; m2_wstrb = 4'h3;
            s_ready  = s_valid && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            exp_owner = done % 2;
            @(negedge clk);
            if (s_valid) begin
                checks++;
                if (s_addr !== (exp_owner == 0 ? m1_addr : m2_addr)) begin
                    failures++; $display("FAIL contention_s_addr: got %h expected %h", s_addr, (exp_owner == 0 ? m1_addr : m2_addr));
                end
                checks++;
                if (s_wstrb !== (exp_owner == 0 ? m1_wstrb : m2_wstrb)) begin
                    failures++; $display("FAIL contention_s_wstrb: got %h expected %h", s_wstrb, (exp_owner == 0 ? m1_wstrb : m2_wstrb));
                end
            end
            got_rdy = {m2_ready, m1_ready};
            if (got_rdy != 2'b00) begin
                exp_rdy = (exp_owner == 0) ? 2'b01 : 2'b10;
                checks++;
                if (got_rdy !== exp_rdy) begin failures++; $display("FAIL contention_owner: got %b expected %b", got_rdy, exp_rdy); end
                $display("txn contention #%0d owner=m%0d", done, got_rdy[1] ? 2 : 1);
                done++;
                if (m1_ready) n1++;
                if (m2_ready) n2++;
            end
            @(posedge clk); #1;
        end
        m1_valid = 1'b0; m2_valid = 1'b0; s_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 6) begin failures++; $display("FAIL contention_count: got %0d expected 6", done); end
    endtask

    task automatic test_timeout();
        int rdy_n = 0, rdy_k = -1, to_n = 0, to_k = -1, m1_n = 0;
        logic [31:0] rd = '0;
        m2_addr = 32'h0000_3000; m2_wstrb = 4'h0; m1_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            m2_valid = (rdy_n == 0);
            s_ready  = (k == 5);
            s_rdata  = 32'h5555_AAAA;
            @(negedge clk);
            if (m2_ready) begin rdy_n++; rdy_k = k; rd = m2_rdata; end
            if (timeout) begin to_n++; to_k = k; end
            if (m1_ready) m1_n++;
            @(posedge clk); #1;
        end
        m2_valid = 1'b0; s_ready = 1'b0;
        checks++; if (rdy_k !== 4) begin failures++; $display("FAIL timeout_ready_cycle: got %0d expected 4", rdy_k); end
        checks++; if (rd !== TO_VALUE) begin failures++; $display("FAIL timeout_rdata: got %h expected %h", rd, TO_VALUE); end
        checks++; if (to_k !== 4) begin failures++; $display("FAIL timeout_pulse_cycle: got %0d expected 4", to_k); end
        checks++; if (to_n !== 1) begin failures++; $display("FAIL timeout_pulse_count: got %0d expected 1", to_n); end
        checks++; if (rdy_n !== 1 || m1_n !== 0) begin failures++; $display("FAIL timeout_late_ready: got m2=%0d m1=%0d expected m2=1 m1=0", rdy_n, m1_n); end
        $display("txn timeout m2 rdata=%h", rd);
    endtask

    task automatic test_coincide();
        int busy_seen = 0, rdy_k = -1, to_n = 0;
        logic [31:0] rd = '0;
        m1_addr = 32'h0000_4000; m1_wstrb = 4'h0; m2_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m1_valid = (rdy_k < 0);
            s_ready  = s_valid && (busy_seen == TO_CYC - 1);
            s_rdata  = s_ready ? 32'h1234_5678 : $urandom;
            if (s_valid) busy_seen++;
            @(negedge clk);
            if (m1_ready && rdy_k < 0) begin rdy_k = k; rd = m1_rdata; end
            if (timeout) to_n++;
            @(posedge clk); #1;
        end
        m1_valid = 1'b0; s_ready = 1'b0;
        checks++; if (rdy_k !== 4) begin failures++; $display("FAIL coincide_ready_cycle: got %0d expected 4", rdy_k); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL coincide_rdata: got %h expected 12345678", rd); end
        checks++; if (to_n !== 0) begin failures++; $display("FAIL coincide_timeout: got %0d pulses expected 0", to_n); end
        $display("txn coincide m1 rdata=%h", rd);
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        m1_addr = 32'h0000_5000; m1_valid = 1'b1; m2_valid = 1'b0; s_ready = 1'b0;
        while (!s_valid && waited < 5) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL resetmid_busy: got s_valid=%b expected 1", s_valid); end
        #3;
        rst = 1'b1;
        s_ready = 1'b1;
        #1;
        checks++; if ({s_valid, grant} !== 3'b000) begin failures++; $display("FAIL resetmid_async: got s_valid=%b grant=%b expected 0 00", s_valid, grant); end
        checks++; if ({m1_ready, m2_ready} !== 2'b00) begin failures++; $display("FAIL resetmid_ready: got %b expected 00", {m1_ready, m2_ready}); end
        @(negedge clk);
        rst = 1'b0; s_ready = 1'b0;
        m1_valid = 1'b1; m2_valid = 1'b1; m2_addr = 32'h0000_6000;
        @(posedge clk); #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL resetmid_tie_grant: got %b expected 01", grant); end
        $display("txn reset_mid tie grant=%b", grant);
        apply_reset();
    endtask

    task automatic test_random();
        int owner = -1, start_c = 0, end_c = -1, lat = 0, txn_n = 0;
        logic last_m2 = 1'b1;
        logic act [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        logic [31:0] oa = '0, owd = '0, exp_rd;
        logic [3:0]  ows = '0;
        logic in_busy, exp_done, exp_to;
        logic [1:0] exp_grant;
        logic [31:0] exp_r1, exp_r2;
        apply_reset();
        for (int i = 0; i < 2; i++) begin act[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1; a[i] = $urandom; wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
                end
            end
            m1_valid = act[0]; m1_addr = a[0]; m1_wdata = wd[0]; m1_wstrb = ws[0];
            m2_valid = act[1]; m2_addr = a[1]; m2_wdata = wd[1]; m2_wstrb = ws[1];
            // A new transfer may start only once the previous one has ended and one idle cycle passed.
            if (c > end_c && (act[0] || act[1])) begin
                if (act[0] && act[1]) owner = last_m2 ? 0 : 1;
                else owner = act[0] ? 0 : 1;
                last_m2 = (owner == 1);
                start_c = c + 1;
                lat     = $urandom_range(0, 6);
                end_c   = start_c + ((lat < TO_CYC) ? lat : TO_CYC - 1);
                oa = a[owner]; owd = wd[owner]; ows = ws[owner];
            end
            in_busy   = (owner >= 0) && (c >= start_c) && (c <= end_c);
            s_ready   = in_busy ? (c == start_c + lat) : ($urandom_range(0, 3) == 0);
            s_rdata   = $urandom;
            exp_done  = in_busy && (c == end_c);
            exp_to    = exp_done && (lat >= TO_CYC);
            exp_rd    = exp_to ? TO_VALUE : s_rdata;
            exp_grant = in_busy ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
            exp_r1    = (exp_done && owner == 0) ? exp_rd : 32'd0;
            exp_r2    = (exp_done && owner == 1) ? exp_rd : 32'd0;
            @(negedge clk);
            checks++; if (s_valid !== in_busy) begin failures++; $display("FAIL rand_s_valid c=%0d: got %b expected %b", c, s_valid, in_busy); end
            checks++; if (grant !== exp_grant) begin failures++; $display("FAIL rand_grant c=%0d: got %b expected %b", c, grant, exp_grant); end
            checks++; if (s_addr !== (in_busy ? oa : 32'd0)) begin failures++; $display("FAIL rand_s_addr c=%0d: got %h expected %h", c, s_addr, (in_busy ? oa : 32'd0)); end
            checks++; if (s_wdata !== (in_busy ? owd : 32'd0)) begin failures++; $display("FAIL rand_s_wdata c=%0d: got %h expected %h", c, s_wdata, (in_busy ? owd : 32'd0)); end
            checks++; if (s_wstrb !== (in_busy ? ows : 4'd0)) begin failures++; $display("FAIL rand_s_wstrb c=%0d: got %h expected %h", c, s_wstrb, (in_busy ? ows : 4'd0)); end
            checks++; if (m1_ready !== (exp_done && owner == 0)) begin failures++; $display("FAIL rand_m1_ready c=%0d: got %b expected %b", c, m1_ready, (exp_done && owner == 0)); end
            checks++; if (m2_ready !== (exp_done && owner == 1)) begin failures++; $display("FAIL rand_m2_ready c=%0d: got %b expected %b", c, m2_ready, (exp_done && owner == 1)); end
            checks++; if (m1_rdata !== exp_r1) begin failures++; $display("FAIL rand_m1_rdata c=%0d: got %h expected %h", c, m1_rdata, exp_r1); end
            checks++; if (m2_rdata !== exp_r2) begin failures++; $display("FAIL rand_m2_rdata c=%0d: got %h expected %h", c, m2_rdata, exp_r2); end
            checks++; if (timeout !== exp_to) begin failures++; $display("FAIL rand_timeout c=%0d: got %b expected %b", c, timeout, exp_to); end
            if (exp_done) begin
                $display("txn rand #%0d m%0d addr=%h wstrb=%h lat=%0d to=%b", txn_n, owner + 1, oa, ows, lat, exp_to);
                txn_n++;
            end
            if (m1_ready) act[0] = 1'b0;
            if (m2_ready) act[1] = 1'b0;
            @(posedge clk); #1;
        end
        m1_valid = 1'b0; m2_valid = 1'b0; s_ready = 1'b0;
        checks++; if (txn_n < 20) begin failures++; $display("FAIL rand_txn_count: got %0d expected at least 20", txn_n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_contention();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
